// File: rtl/dp_ram_fifo_ctrl.sv
// FIFO controller for an external simple dual-port RAM with a 2-entry FWFT output queue.
// Latency: a word pushed into an empty block shows on rd_valid/rd_data 3 cycles later.
// Backpressure: wr_ready drops only when the RAM is full. rd_ready may stall at any time, and the
//   output queue absorbs the one-cycle RAM read latency, so streaming runs at one word per cycle.
//
// Ports:
//   clk, rst                      single clock, synchronous active-high reset
//   wr_valid/wr_ready/wr_data     producer handshake (push)
//   rd_valid/rd_ready/rd_data     consumer handshake (pop), rd_data is the head word
//   count                         words held: RAM + output queue + read in flight
//   ram_we/ram_waddr/ram_din      RAM write port
//   ram_raddr/ram_dout            RAM read port, dout valid one cycle after raddr
module dp_ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   ram_used_q, ram_used_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [1:0]            out_cnt_q, out_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;

  logic       push, pop, fetch;
  logic [2:0] occ;
  logic [1:0] out_after_pop;

  // wr_ready looks only at registered RAM occupancy, so it never waits on this cycle's fetch or pop.
  assign wr_ready  = (ram_used_q != DEPTH_C);
  assign rd_valid  = (out_cnt_q != 2'd0);
  assign rd_data   = head_q;
  assign count     = count_q;
  assign ram_we    = push && !rst;
  assign ram_waddr = wptr_q;
  assign ram_din   = wr_data;
  assign ram_raddr = rptr_q;

  always_comb begin
    push = wr_valid && wr_ready;
    pop  = rd_valid && rd_ready;

    // Output-queue slots already spoken for once this cycle's pop leaves. A read in flight
    // has a slot reserved, so the queue can never overflow.
    occ   = 3'(out_cnt_q) + 3'(inflight_q) - 3'(pop);
    fetch = (ram_used_q != '0) && (occ < 3'd2);

    wptr_d     = push  ? wptr_q + ADDR_WIDTH'(1) : wptr_q;
    rptr_d     = fetch ? rptr_q + ADDR_WIDTH'(1) : rptr_q;
    inflight_d = fetch;

    ram_used_d = ram_used_q;
    if (push && !fetch) ram_used_d = ram_used_q + (ADDR_WIDTH+1)'(1);
    if (!push && fetch) ram_used_d = ram_used_q - (ADDR_WIDTH+1)'(1);

    count_d = count_q;
    if (push && !pop) count_d = count_q + (ADDR_WIDTH+1)'(1);
    if (!push && pop) count_d = count_q - (ADDR_WIDTH+1)'(1);

    // Pop shifts first. The returning RAM word then lands in the first free slot.
    head_d        = pop ? tail_q : head_q;
    tail_d        = tail_q;
    out_after_pop = out_cnt_q - 2'(pop);
    if (inflight_q) begin
      if (out_after_pop == 2'd0) head_d = ram_dout;
      else                       tail_d = ram_dout;
    end
    out_cnt_d = out_after_pop + 2'(inflight_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_used_q <= '0;
      count_q    <= '0;
      out_cnt_q  <= '0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ram_used_q <= ram_used_d;
      count_q    <= count_d;
      out_cnt_q  <= out_cnt_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

endmodule
